riscv_exe_stage: RTL and testbench

//  Execute stage of the pipelined RV32I core. Consumes the decode/execute register outputs and applies operand forwarding.

---
 rtl/riscv_exe_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_riscv_exe_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_exe_stage.sv
// Execute stage of the RV32I pipeline: forwarding, ALU, branch/jump resolution and the E/M register.
// Define RISCV_MULDIV_EN to build the iterative RV32M unit (33-cycle stall per op); otherwise M ops run as plain ALU ops.
module riscv_exe_stage #(
  parameter logic [31:0] REGISTER_INIT = '0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_exe_src_pc,
  input  logic        i_exe_src_alu_a,
  input  logic        i_exe_src_alu_b,
  input  logic [3:0]  i_exe_alu_ctrl,
  input  logic        i_exe_muldiv,
  input  logic [2:0]  i_exe_func3,
  input  logic [31:0] i_exe_rs1_data,
  input  logic [31:0] i_exe_rs2_data,
  input  logic [31:0] i_exe_pc,
  input  logic [31:0] i_exe_imm_ext,
  input  logic [31:0] i_exe_pcplus4,
  input  logic [4:0]  i_exe_rd_addr,
  input  logic [1:0]  i_exe_src_rd,
  input  logic        i_exe_reg_wr_en,
  input  logic        i_exe_mem_wr_en,
  input  logic [3:0]  i_exe_mem_byte_sel,
  input  logic [1:0]  i_exe_fwd_a,
  input  logic [1:0]  i_exe_fwd_b,
  input  logic [31:0] i_exe_m_result,
  input  logic [31:0] i_exe_w_result,
  input  logic        i_em_en,
  input  logic        i_em_clear,
  output logic [31:0] o_exe_pc_target,
  output logic        o_exe_pc_redirect,
  output logic        o_exe_stall,
  output logic [31:0] o_em_alu_result,
  output logic [31:0] o_em_wr_data,
  output logic [4:0]  o_em_rd_addr,
  output logic [1:0]  o_em_src_rd,
  output logic        o_em_reg_wr_en,
  output logic        o_em_mem_wr_en,
  output logic [3:0]  o_em_mem_byte_sel,
  output logic [31:0] o_em_pcplus4,
  output logic [1:0]  o_dbg_md_state
);

  // Handshake: o_exe_stall=1 means E holds its instruction; upstream must freeze and E/M receives a bubble.
  logic [31:0] fwd_rs1, fwd_rs2, alu_a, alu_b, alu_out, exe_result, tgt_sum;
  logic        br_taken, exe_stall;

  always_comb begin
    case (i_exe_fwd_a)
      2'd1:    fwd_rs1 = i_exe_w_result;
      2'd2:    fwd_rs1 = i_exe_m_result;
      default: fwd_rs1 = i_exe_rs1_data;
    endcase
    case (i_exe_fwd_b)
      2'd1:    fwd_rs2 = i_exe_w_result;
      2'd2:    fwd_rs2 = i_exe_m_result;
      default: fwd_rs2 = i_exe_rs2_data;
    endcase
  end

  assign alu_a = i_exe_src_alu_a ? i_exe_pc : fwd_rs1;
  assign alu_b = i_exe_src_alu_b ? i_exe_imm_ext : fwd_rs2;

  always_comb begin
    case (i_exe_alu_ctrl)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd2:    alu_out = alu_a << alu_b[4:0];
      4'd3:    alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd4:    alu_out = {31'd0, alu_a < alu_b};
      4'd5:    alu_out = alu_a ^ alu_b;
      4'd6:    alu_out = alu_a >> alu_b[4:0];
      4'd7:    alu_out = $signed(alu_a) >>> alu_b[4:0];
      4'd8:    alu_out = alu_a | alu_b;
      4'd9:    alu_out = alu_a & alu_b;
      4'd10:   alu_out = alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  always_comb begin
    case (i_exe_func3)
      3'b000:  br_taken = (fwd_rs1 == fwd_rs2);
      3'b001:  br_taken = (fwd_rs1 != fwd_rs2);
      3'b100:  br_taken = ($signed(fwd_rs1) < $signed(fwd_rs2));
      3'b101:  br_taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      3'b110:  br_taken = (fwd_rs1 < fwd_rs2);
      3'b111:  br_taken = (fwd_rs1 >= fwd_rs2);
      default: br_taken = 1'b0;
    endcase
  end

  assign tgt_sum         = ((i_exe_src_pc == 2'd3) ? fwd_rs1 : i_exe_pc) + i_exe_imm_ext;
  assign o_exe_pc_target = (i_exe_src_pc == 2'd3) ? {tgt_sum[31:1], 1'b0} : tgt_sum;
  assign o_exe_pc_redirect = ((i_exe_src_pc == 2'd2) || (i_exe_src_pc == 2'd3) ||
                              ((i_exe_src_pc == 2'd1) && br_taken)) && !exe_stall;
  assign o_exe_stall = exe_stall;

`ifdef RISCV_MULDIV_EN
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_t;
  md_state_t   md_state, md_next;
  logic        md_start, md_done;
  logic [4:0]  md_cnt;
  logic [2:0]  md_f3;
  logic [31:0] md_hi, md_lo, md_b, md_result;
  logic        md_neg_q, md_neg_r;
  logic        a_sgn, b_sgn;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [33:0] div_try;
  logic [63:0] prod_fix;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) md_state <= MD_IDLE;
    else       md_state <= md_next;
  end

  always_comb begin
    md_next = md_state;
    case (md_state)
      MD_IDLE: if (i_exe_muldiv && !i_em_clear) md_next = MD_BUSY;
      MD_BUSY: if (i_em_clear) md_next = MD_IDLE;
               else if (md_cnt == 5'd31) md_next = MD_DONE;
      MD_DONE: if (i_em_clear || i_em_en) md_next = MD_IDLE;
      default: md_next = MD_IDLE;
    endcase
  end

  always_comb begin
    md_start  = (md_state == MD_IDLE) && i_exe_muldiv && !i_em_clear;
    md_done   = (md_state == MD_DONE);
    exe_stall = md_start || (md_state == MD_BUSY);
  end

  // Operands are made unsigned up front; signs are re-applied to the final result.
  always_comb begin
    if (i_exe_func3[2]) begin
      a_sgn = !i_exe_func3[0] && fwd_rs1[31];
      b_sgn = !i_exe_func3[0] && fwd_rs2[31];
    end else begin
      a_sgn = (i_exe_func3[1:0] == 2'b01 || i_exe_func3[1:0] == 2'b10) && fwd_rs1[31];
      b_sgn = (i_exe_func3[1:0] == 2'b01) && fwd_rs2[31];
    end
    a_abs = a_sgn ? (~fwd_rs1 + 32'd1) : fwd_rs1;
    b_abs = b_sgn ? (~fwd_rs2 + 32'd1) : fwd_rs2;
  end

  assign mul_sum = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : 33'd0);
  assign div_try = {1'b0, md_hi, md_lo[31]} - {2'b00, md_b};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      md_cnt <= '0; md_f3 <= '0; md_hi <= '0; md_lo <= '0; md_b <= '0;
      md_neg_q <= 1'b0; md_neg_r <= 1'b0;
    end else if (md_start) begin
      md_cnt <= '0;
      md_f3  <= i_exe_func3;
      md_hi  <= '0;
      md_lo  <= i_exe_func3[2] ? a_abs : b_abs;
      md_b   <= i_exe_func3[2] ? b_abs : a_abs;
      // A zero divisor keeps the quotient at all-ones regardless of sign.
      md_neg_q <= (a_sgn ^ b_sgn) && !(i_exe_func3[2] && (fwd_rs2 == 32'd0));
      md_neg_r <= a_sgn;
    end else if (md_state == MD_BUSY) begin
      md_cnt <= md_cnt + 5'd1;
      if (!md_f3[2]) begin
        md_hi <= mul_sum[32:1];
        md_lo <= {mul_sum[0], md_lo[31:1]};
      end else if (!div_try[33]) begin
        md_hi <= div_try[31:0];
        md_lo <= {md_lo[30:0], 1'b1};
      end else begin
        md_hi <= {md_hi[30:0], md_lo[31]};
        md_lo <= {md_lo[30:0], 1'b0};
      end
    end
  end

  assign prod_fix = md_neg_q ? (~{md_hi, md_lo} + 64'd1) : {md_hi, md_lo};

  always_comb begin
    if (!md_f3[2])      md_result = (md_f3[1:0] == 2'b00) ? md_lo : prod_fix[63:32];
    else if (!md_f3[1]) md_result = md_neg_q ? (~md_lo + 32'd1) : md_lo;
    else                md_result = md_neg_r ? (~md_hi + 32'd1) : md_hi;
  end

  assign exe_result     = md_done ? md_result : alu_out;
  assign o_dbg_md_state = md_state;
`else
  logic unused_muldiv;
  assign unused_muldiv  = i_exe_muldiv;
  assign exe_stall      = 1'b0;
  assign exe_result     = alu_out;
  assign o_dbg_md_state = 2'd0;
`endif

  // E/M register: clear > stall bubble > load > hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_em_clear) begin
      o_em_alu_result   <= REGISTER_INIT;
      o_em_wr_data      <= REGISTER_INIT;
      o_em_rd_addr      <= REGISTER_INIT[4:0];
      o_em_src_rd       <= REGISTER_INIT[1:0];
      o_em_reg_wr_en    <= REGISTER_INIT[0];
      o_em_mem_wr_en    <= REGISTER_INIT[0];
      o_em_mem_byte_sel <= REGISTER_INIT[3:0];
      o_em_pcplus4      <= REGISTER_INIT;
    end else if (exe_stall) begin
      o_em_reg_wr_en <= 1'b0;
      o_em_mem_wr_en <= 1'b0;
    end else if (i_em_en) begin
      o_em_alu_result   <= exe_result;
      o_em_wr_data      <= fwd_rs2;
      o_em_rd_addr      <= i_exe_rd_addr;
      o_em_src_rd       <= i_exe_src_rd;
      o_em_reg_wr_en    <= i_exe_reg_wr_en;
      o_em_mem_wr_en    <= i_exe_mem_wr_en;
      o_em_mem_byte_sel <= i_exe_mem_byte_sel;
      o_em_pcplus4      <= i_exe_pcplus4;
    end
  end

endmodule

// File: tb/tb_riscv_exe_stage.sv
// Directed bench for riscv_exe_stage: ALU, forwarding, branches, E/M control and, with RISCV_MULDIV_EN, the mul/div unit.
module tb_riscv_exe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_pc;
  logic        src_alu_a, src_alu_b, muldiv, reg_wr_en, mem_wr_en, em_en, em_clear;
  logic [3:0]  alu_ctrl, byte_sel;
  logic [2:0]  func3;
  logic [31:0] rs1, rs2, pc, imm, pcplus4, m_result, w_result;
  logic [4:0]  rd_addr;
  logic [1:0]  src_rd, fwd_a, fwd_b;
  logic [31:0] pc_target, em_alu_result, em_wr_data, em_pcplus4;
  logic        pc_redirect, stall, em_reg_wr_en, em_mem_wr_en;
  logic [4:0]  em_rd_addr;
  logic [1:0]  em_src_rd, dbg_state;
  logic [3:0]  em_byte_sel;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  riscv_exe_stage dut (
    .i_clk(clk), .i_rst(rst), .i_exe_src_pc(src_pc), .i_exe_src_alu_a(src_alu_a),
    .i_exe_src_alu_b(src_alu_b), .i_exe_alu_ctrl(alu_ctrl), .i_exe_muldiv(muldiv),
    .i_exe_func3(func3), .i_exe_rs1_data(rs1), .i_exe_rs2_data(rs2), .i_exe_pc(pc),
    .i_exe_imm_ext(imm), .i_exe_pcplus4(pcplus4), .i_exe_rd_addr(rd_addr),
    .i_exe_src_rd(src_rd), .i_exe_reg_wr_en(reg_wr_en), .i_exe_mem_wr_en(mem_wr_en),
    .i_exe_mem_byte_sel(byte_sel), .i_exe_fwd_a(fwd_a), .i_exe_fwd_b(fwd_b),
    .i_exe_m_result(m_result), .i_exe_w_result(w_result), .i_em_en(em_en),
    .i_em_clear(em_clear), .o_exe_pc_target(pc_target), .o_exe_pc_redirect(pc_redirect),
    .o_exe_stall(stall), .o_em_alu_result(em_alu_result), .o_em_wr_data(em_wr_data),
    .o_em_rd_addr(em_rd_addr), .o_em_src_rd(em_src_rd), .o_em_reg_wr_en(em_reg_wr_en),
    .o_em_mem_wr_en(em_mem_wr_en), .o_em_mem_byte_sel(em_byte_sel),
    .o_em_pcplus4(em_pcplus4), .o_dbg_md_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    src_pc = 2'd0; src_alu_a = 1'b0; src_alu_b = 1'b0; alu_ctrl = 4'd0; muldiv = 1'b0;
    func3 = 3'd0; rs1 = '0; rs2 = '0; pc = '0; imm = '0; pcplus4 = '0; rd_addr = '0;
    src_rd = '0; reg_wr_en = 1'b0; mem_wr_en = 1'b0; byte_sel = '0; fwd_a = '0; fwd_b = '0;
    m_result = '0; w_result = '0; em_en = 1'b1; em_clear = 1'b0;
  endtask

  task automatic test_reset();
    set_defaults();
    alu_ctrl = 4'd10; src_alu_b = 1'b1; imm = 32'hDEADBEEF; rd_addr = 5'd5; reg_wr_en = 1'b1;
    tick();
    total_cnt++;
    if (em_alu_result !== 32'hDEADBEEF) $display("FAIL pre_reset_load: got %h want deadbeef", em_alu_result);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (em_alu_result !== 32'd0) $display("FAIL reset_alu: got %h want 0", em_alu_result); else pass_cnt++;
    total_cnt++;
    if (em_reg_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", em_reg_wr_en); else pass_cnt++;
    total_cnt++;
    if (em_rd_addr !== 5'd0) $display("FAIL reset_rd: got %h want 0", em_rd_addr); else pass_cnt++;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    set_defaults();
  endtask

  task automatic test_alu();
    logic [31:0] exp_v [12];
    logic [3:0]  ops   [12];
    exp_v = '{32'hF0000029, 32'hEFFFFFE1, 32'h00000050, 32'h1, 32'h0, 32'hF0000021,
              32'h0F000000, 32'hFF000000, 32'hF0000025, 32'h00000004, 32'h24, 32'h0};
    ops   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};
    set_defaults();
    rs1 = 32'hF0000005; rs2 = 32'h00000024;
    for (int i = 0; i < 12; i++) begin
      alu_ctrl = ops[i];
      tick();
      total_cnt++;
      if (em_alu_result !== exp_v[i]) $display("FAIL alu_op%0d: got %h want %h", ops[i], em_alu_result, exp_v[i]);
      else pass_cnt++;
    end
    // Forwarding and operand source selects
    set_defaults();
    fwd_a = 2'd2; m_result = 32'd5; src_alu_b = 1'b1; imm = 32'd7;
    tick();
    total_cnt++;
    if (em_alu_result !== 32'd12) $display("FAIL fwd_m_add: got %h want 12", em_alu_result); else pass_cnt++;
    fwd_a = 2'd0; rs1 = 32'd100; fwd_b = 2'd1; w_result = 32'd30; src_alu_b = 1'b0; alu_ctrl = 4'd1;
    tick();
    total_cnt++;
    if (em_alu_result !== 32'd70) $display("FAIL fwd_w_sub: got %h want 70", em_alu_result); else pass_cnt++;
    total_cnt++;
    if (em_wr_data !== 32'd30) $display("FAIL fwd_w_store: got %h want 1e", em_wr_data); else pass_cnt++;
    fwd_a = 2'd3; fwd_b = 2'd0; rs2 = 32'd1; alu_ctrl = 4'd0; m_result = 32'd9; w_result = 32'd9;
    tick();
    total_cnt++;
    if (em_alu_result !== 32'd101) $display("FAIL fwd_sel3: got %h want 65", em_alu_result); else pass_cnt++;
    src_alu_a = 1'b1; pc = 32'h400; src_alu_b = 1'b1; imm = 32'h10;
    tick();
    total_cnt++;
    if (em_alu_result !== 32'h410) $display("FAIL auipc_add: got %h want 410", em_alu_result); else pass_cnt++;
  endtask

  task automatic test_branch();
    logic [2:0]  f3v [8];
    logic [31:0] av  [8];
    logic [31:0] bv  [8];
    logic        tk  [8];
    f3v = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111, 3'b010, 3'b011};
    av  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd1, 32'd1, 32'd7, 32'd7};
    bv  = '{32'd1, 32'd1, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7};
    tk  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    set_defaults();
    src_pc = 2'd1; pc = 32'h100; imm = 32'h20;
    for (int i = 0; i < 8; i++) begin
      func3 = f3v[i]; rs1 = av[i]; rs2 = bv[i];
      #1;
      total_cnt++;
      if (pc_redirect !== tk[i]) $display("FAIL branch_f3_%0d: got %b want %b", f3v[i], pc_redirect, tk[i]);
      else pass_cnt++;
    end
    func3 = 3'b100; rs1 = 32'hFFFFFFFF; rs2 = 32'd1;
    #1;
    total_cnt++;
    if (pc_target !== 32'h120) $display("FAIL branch_target: got %h want 120", pc_target); else pass_cnt++;
    func3 = 3'b000; rs1 = 32'd7; rs2 = 32'd0; fwd_b = 2'd2; m_result = 32'd7;
    #1;
    total_cnt++;
    if (pc_redirect !== 1'b1) $display("FAIL branch_fwd_beq: got %b want 1", pc_redirect); else pass_cnt++;
    src_pc = 2'd0;
    #1;
    total_cnt++;
    if (pc_redirect !== 1'b0) $display("FAIL seq_no_redirect: got %b want 0", pc_redirect); else pass_cnt++;
    src_pc = 2'd2; pc = 32'h200; imm = 32'hFFFFFFF0;
    #1;
    total_cnt++;
    if (pc_target !== 32'h1F0 || pc_redirect !== 1'b1)
      $display("FAIL jal: got %h/%b want 1f0/1", pc_target, pc_redirect);
    else pass_cnt++;
  endtask

  task automatic test_jalr_hold_clear();
    set_defaults();
    src_pc = 2'd3; rs1 = 32'h1003; imm = 32'd0;
    #1;
    total_cnt++;
    if (pc_target !== 32'h1002 || pc_redirect !== 1'b1)
      $display("FAIL jalr: got %h/%b want 1002/1", pc_target, pc_redirect);
    else pass_cnt++;
    set_defaults();
    alu_ctrl = 4'd10; src_alu_b = 1'b1; imm = 32'h55; rs2 = 32'hCAFE; rd_addr = 5'd3;
    src_rd = 2'd2; reg_wr_en = 1'b1; mem_wr_en = 1'b1; byte_sel = 4'hF; pcplus4 = 32'h104;
    tick();
    total_cnt++;
    if ({em_wr_data, em_rd_addr, em_src_rd, em_mem_wr_en, em_byte_sel, em_pcplus4} !==
        {32'hCAFE, 5'd3, 2'd2, 1'b1, 4'hF, 32'h104})
      $display("FAIL passthrough: got %h %h %h %b %h %h want cafe 03 2 1 f 104",
               em_wr_data, em_rd_addr, em_src_rd, em_mem_wr_en, em_byte_sel, em_pcplus4);
    else pass_cnt++;
    imm = 32'h66; rd_addr = 5'd9; em_en = 1'b0;
    tick();
    total_cnt++;
    if (em_alu_result !== 32'h55 || em_rd_addr !== 5'd3)
      $display("FAIL hold: got %h/%h want 55/03", em_alu_result, em_rd_addr);
    else pass_cnt++;
    em_clear = 1'b1;
    tick();
    total_cnt++;
    if (em_alu_result !== 32'd0 || em_reg_wr_en !== 1'b0 || em_rd_addr !== 5'd0)
      $display("FAIL clear_no_en: got %h/%b/%h want 0/0/0", em_alu_result, em_reg_wr_en, em_rd_addr);
    else pass_cnt++;
    em_clear = 1'b0; em_en = 1'b1;
    tick();
    em_clear = 1'b1;
    tick();
    total_cnt++;
    if (em_alu_result !== 32'd0 || em_mem_wr_en !== 1'b0)
      $display("FAIL clear_over_en: got %h/%b want 0/0", em_alu_result, em_mem_wr_en);
    else pass_cnt++;
    set_defaults();
  endtask

`ifdef RISCV_MULDIV_EN
  task automatic md_run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int n, output int bubble_err);
    set_defaults();
    muldiv = 1'b1; func3 = f3; rs1 = a; rs2 = b; reg_wr_en = 1'b1;
    n = 0; bubble_err = 0;
    #1;
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick();
      if (em_reg_wr_en !== 1'b0) bubble_err++;
    end
    tick();
    res = em_alu_result;
    muldiv = 1'b0;
  endtask

  task automatic test_muldiv();
    logic [2:0]  f3v [6];
    logic [31:0] av  [6];
    logic [31:0] bv  [6];
    logic [31:0] ev  [6];
    logic [31:0] res;
    int          n, be;
    f3v = '{3'b100, 3'b101, 3'b011, 3'b000, 3'b001, 3'b110};
    av  = '{32'h80000000, 32'h1234, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFF9};
    bv  = '{32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd5, 32'd5, 32'd2};
    ev  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      md_run(f3v[i], av[i], bv[i], res, n, be);
      total_cnt++;
      if (res !== ev[i]) $display("FAIL md_f3_%0d_result: got %h want %h", f3v[i], res, ev[i]);
      else pass_cnt++;
      total_cnt++;
      if (n != 33) $display("FAIL md_f3_%0d_stall_cycles: got %0d want 33", f3v[i], n);
      else pass_cnt++;
      total_cnt++;
      if (be != 0 || em_reg_wr_en !== 1'b1)
        $display("FAIL md_f3_%0d_bubbles: got %0d errs wr_en %b want 0 errs wr_en 1", f3v[i], be, em_reg_wr_en);
      else pass_cnt++;
    end
  endtask

  task automatic test_md_abort();
    set_defaults();
    muldiv = 1'b1; func3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; reg_wr_en = 1'b1;
    tick();
    repeat (10) tick();
    total_cnt++;
    if (stall !== 1'b1 || dbg_state !== 2'd1)
      $display("FAIL abort_busy: got stall %b state %0d want 1/1", stall, dbg_state);
    else pass_cnt++;
    em_clear = 1'b1;
    tick();
    total_cnt++;
    if (stall !== 1'b0 || dbg_state !== 2'd0 || em_alu_result !== 32'd0)
      $display("FAIL abort_idle: got stall %b state %0d alu %h want 0/0/0", stall, dbg_state, em_alu_result);
    else pass_cnt++;
    set_defaults();
  endtask
`else
  task automatic test_muldiv_ignored();
    set_defaults();
    muldiv = 1'b1; func3 = 3'b100; rs1 = 32'd20; rs2 = 32'd22;
    #1;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL md_off_stall: got %b want 0", stall); else pass_cnt++;
    tick();
    total_cnt++;
    if (em_alu_result !== 32'd42) $display("FAIL md_off_add: got %h want 2a", em_alu_result); else pass_cnt++;
    set_defaults();
  endtask
`endif

  initial begin
    set_defaults();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_jalr_hold_clear();
`ifdef RISCV_MULDIV_EN
    test_muldiv();
    test_md_abort();
`else
    test_muldiv_ignored();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
